// File: rtl/video_pkg.sv
// Shared definitions for the video RAM arbiter: slot encodings,
// the scroll-wrap length table and the default teletext base.
package video_pkg;

  typedef enum logic [0:0] {
    S_VID = 1'b0,
    S_CPU = 1'b1
  } slot_t;

  localparam int          ADR_W_DEF    = 15;
  localparam logic [14:0] TTX_BASE_DEF = 15'h7C00;

  // Screen length subtracted when the CRTC address runs past the top of RAM.
  function automatic logic [14:0] wrap_len(input logic [1:0] screen_size);
    logic [14:0] len;
    case (screen_size)
      2'b00:   len = 15'h5000;
      2'b01:   len = 15'h4000;
      2'b10:   len = 15'h2800;
      2'b11:   len = 15'h2000;
      default: len = 15'h5000;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/video_adr_xlate.sv
// Combinational CRTC (MA, RA) to physical screen-RAM address translation:
// linear bitmap, hardware-scroll wrap and the teletext window.
module video_adr_xlate
  import video_pkg::*;
#(
  parameter logic [14:0] TTX_BASE = TTX_BASE_DEF
) (
  input  logic [13:0] ma,
  input  logic [4:0]  ra,
  input  logic [1:0]  screen_size,
  output logic [14:0] vid_adr
);

  logic [14:0] raw_s;
  logic        ra_unused_s;

  assign raw_s       = {ma[11:0], ra[2:0]};
  assign ra_unused_s = ^ra[4:3];

  // Borrow out of the wrap subtraction is dropped on purpose: the result
  // folds back into the top of the 32 KB space.
  always_comb begin
    vid_adr = raw_s;
    if (ma[13]) begin
      vid_adr = TTX_BASE | {5'b00000, ma[9:0]};
    end else if (ma[12]) begin
      vid_adr = raw_s - wrap_len(screen_size);
    end else begin
      vid_adr = raw_s;
    end
  end

endmodule

// File: rtl/video_ram_arbiter.sv
// Time-slices a single-port screen RAM between video fetches and CPU
// accesses; each RAM_en strobe closes one slot and opens the next.
module video_ram_arbiter
  import video_pkg::*;
#(
  parameter int          ADR_W    = ADR_W_DEF,
  parameter logic [14:0] TTX_BASE = TTX_BASE_DEF
) (
  input  logic             PIXELCLK,
  input  logic             nRESET,
  input  logic             RAM_en,
  input  logic             PROC_en,
  input  logic [13:0]      FRAMESTORE_ADR,
  input  logic [4:0]       ROW_ADDRESS,
  input  logic [1:0]       SCREEN_SIZE,
  input  logic             CPU_REQ,
  input  logic             CPU_RnW,
  input  logic [ADR_W-1:0] CPU_ADR,
  input  logic [7:0]       CPU_DO,
  input  logic [7:0]       RAM_DI,
  output logic [ADR_W-1:0] RAM_ADR,
  output logic [7:0]       RAM_DO,
  output logic             RAM_nWE,
  output logic [7:0]       vDATABUS,
  output logic             VID_VALID,
  output logic [7:0]       CPU_DI
);

  slot_t       slot_r;
  slot_t       slot_nxt_s;
  logic [14:0] vid_adr_s;
  logic        start_vid_s;
  logic        start_cpu_s;
  logic        cpu_wr_s;
  logic        cpu_rd_s;
  logic        end_vid_s;
  logic        end_rd_s;
  logic        pend_vid_r;
  logic        pend_rd_r;

  video_adr_xlate #(
    .TTX_BASE(TTX_BASE)
  ) u_xlate (
    .ma         (FRAMESTORE_ADR),
    .ra         (ROW_ADDRESS),
    .screen_size(SCREEN_SIZE),
    .vid_adr    (vid_adr_s)
  );

  // Slot state register.
  always_ff @(posedge PIXELCLK) begin
    if (!nRESET) begin
      slot_r <= S_VID;
    end else begin
      slot_r <= slot_nxt_s;
    end
  end

  // Next slot: PROC_en forces a CPU slot, otherwise slots alternate.
  always_comb begin
    slot_nxt_s = slot_r;
    if (RAM_en) begin
      if (PROC_en) begin
        slot_nxt_s = S_CPU;
      end else begin
        case (slot_r)
          S_VID:   slot_nxt_s = S_CPU;
          S_CPU:   slot_nxt_s = S_VID;
          default: slot_nxt_s = S_VID;
        endcase
      end
    end else begin
      slot_nxt_s = slot_r;
    end
  end

  // Slot boundary decode shared by the output registers.
  always_comb begin
    start_vid_s = RAM_en && (slot_nxt_s == S_VID);
    start_cpu_s = RAM_en && (slot_nxt_s == S_CPU);
    cpu_wr_s    = start_cpu_s && CPU_REQ && !CPU_RnW;
    cpu_rd_s    = start_cpu_s && CPU_REQ && CPU_RnW;
    end_vid_s   = RAM_en && pend_vid_r;
    end_rd_s    = RAM_en && pend_rd_r;
  end

  // Output and capture registers; CPU inputs are taken only at slot start.
  always_ff @(posedge PIXELCLK) begin
    if (!nRESET) begin
      RAM_ADR    <= '0;
      RAM_DO     <= 8'h00;
      RAM_nWE    <= 1'b1;
      vDATABUS   <= 8'h00;
      VID_VALID  <= 1'b0;
      CPU_DI     <= 8'h00;
      pend_vid_r <= 1'b0;
      pend_rd_r  <= 1'b0;
    end else begin
      VID_VALID <= end_vid_s;
      if (end_vid_s) begin
        vDATABUS <= RAM_DI;
      end
      if (end_rd_s) begin
        CPU_DI <= RAM_DI;
      end
      if (RAM_en) begin
        pend_vid_r <= start_vid_s;
        pend_rd_r  <= cpu_rd_s;
      end
      if (start_vid_s) begin
        RAM_ADR <= vid_adr_s;
        RAM_nWE <= 1'b1;
      end else if (start_cpu_s) begin
        RAM_ADR <= CPU_ADR;
        RAM_nWE <= !cpu_wr_s;
        if (cpu_wr_s) begin
          RAM_DO <= CPU_DO;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_ram_arbiter.sv
// Randomised bench for video_ram_arbiter against a slot-level behavioural
// model with a small RAM, plus directed address and capture scenarios.
module tb_video_ram_arbiter;

  logic        clk = 1'b0;
  logic        nRESET, RAM_en, PROC_en, CPU_REQ, CPU_RnW;
  logic [13:0] FRAMESTORE_ADR;
  logic [4:0]  ROW_ADDRESS;
  logic [1:0]  SCREEN_SIZE;
  logic [14:0] CPU_ADR, RAM_ADR;
  logic [7:0]  CPU_DO, RAM_DI, RAM_DO, vDATABUS, CPU_DI;
  logic        RAM_nWE, VID_VALID;

  always #5 clk = ~clk;

  video_ram_arbiter dut (
    .PIXELCLK(clk), .nRESET(nRESET), .RAM_en(RAM_en), .PROC_en(PROC_en),
    .FRAMESTORE_ADR(FRAMESTORE_ADR), .ROW_ADDRESS(ROW_ADDRESS),
    .SCREEN_SIZE(SCREEN_SIZE), .CPU_REQ(CPU_REQ), .CPU_RnW(CPU_RnW),
    .CPU_ADR(CPU_ADR), .CPU_DO(CPU_DO), .RAM_DI(RAM_DI), .RAM_ADR(RAM_ADR),
    .RAM_DO(RAM_DO), .RAM_nWE(RAM_nWE), .vDATABUS(vDATABUS),
    .VID_VALID(VID_VALID), .CPU_DI(CPU_DI)
  );

  // 256-byte RAM aliased on address bits [7:0]; written only by the model.
  logic [7:0] mem [0:255];
  logic       poke_en;
  logic [7:0] poke_idx, poke_dat;
  assign RAM_DI = mem[RAM_ADR[7:0]];

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [14:0] ref_adr(input logic [13:0] ma, input logic [4:0] ra,
                                          input logic [1:0] ss);
    int raw, len;
    if (ma[13]) return 15'(32'h7C00 + (int'(ma) % 1024));
    raw = (int'(ma) % 4096) * 8 + (int'(ra) % 8);
    case (ss)
      2'd0:    len = 20480;
      2'd1:    len = 16384;
      2'd2:    len = 10240;
      default: len = 8192;
    endcase
    if (ma[12]) raw = (raw + 32768 - len) % 32768;
    return 15'(raw);
  endfunction

  // Model: kind of the open slot (0 none, 1 video, 2 cpu read, 3 cpu write).
  logic [14:0] e_adr;
  logic [7:0]  e_do, e_vd, e_di;
  logic        e_nwe, e_valid, m_cpu, started = 1'b0;
  int          m_kind;

  always @(posedge clk) begin
    started <= 1'b1;
    if (!nRESET) begin
      e_adr <= 15'h0000; e_do <= 8'h00; e_nwe <= 1'b1; e_vd <= 8'h00;
      e_di <= 8'h00; e_valid <= 1'b0; m_kind <= 0; m_cpu <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 19);
    end else begin
      e_valid <= 1'b0;
      if (poke_en) mem[poke_idx] <= poke_dat;
      if (RAM_en) begin
        if (m_kind == 1) begin e_vd <= mem[e_adr[7:0]]; e_valid <= 1'b1; end
        if (m_kind == 2) e_di <= mem[e_adr[7:0]];
        if (m_kind == 3) mem[e_adr[7:0]] <= e_do;
        if (PROC_en || !m_cpu) begin
          m_cpu <= 1'b1;
          e_adr <= CPU_ADR;
          if (CPU_REQ && !CPU_RnW) begin
            e_nwe <= 1'b0; e_do <= CPU_DO; m_kind <= 3;
          end else begin
            e_nwe <= 1'b1; m_kind <= CPU_REQ ? 2 : 0;
          end
        end else begin
          m_cpu <= 1'b0;
          e_adr <= ref_adr(FRAMESTORE_ADR, ROW_ADDRESS, SCREEN_SIZE);
          e_nwe <= 1'b1;
          m_kind <= 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic tick;
    @(negedge clk);
    if (started) begin
      chk("RAM_ADR", 32'(RAM_ADR), 32'(e_adr));
      chk("RAM_nWE", 32'(RAM_nWE), 32'(e_nwe));
      chk("RAM_DO", 32'(RAM_DO), 32'(e_do));
      chk("vDATABUS", 32'(vDATABUS), 32'(e_vd));
      chk("VID_VALID", 32'(VID_VALID), 32'(e_valid));
      chk("CPU_DI", 32'(CPU_DI), 32'(e_di));
    end
  endtask

  task automatic pulse(input logic proc);
    RAM_en = 1'b1; PROC_en = proc;
    tick();
    RAM_en = 1'b0; PROC_en = 1'b0;
  endtask

  task automatic start_vid;
    if (!m_cpu) pulse(1'b0);
    pulse(1'b0);
  endtask

  task automatic poke(input logic [7:0] idx, input logic [7:0] dat);
    poke_en = 1'b1; poke_idx = idx; poke_dat = dat;
    tick();
    poke_en = 1'b0;
  endtask

  initial begin
    nRESET = 1'b0; RAM_en = 1'b0; PROC_en = 1'b0; CPU_REQ = 1'b0; CPU_RnW = 1'b1;
    FRAMESTORE_ADR = 14'h0000; ROW_ADDRESS = 5'd0; SCREEN_SIZE = 2'b00;
    CPU_ADR = 15'h0000; CPU_DO = 8'h00; poke_en = 1'b0; poke_idx = 8'h00; poke_dat = 8'h00;
    tick();
    repeat (3) begin
      RAM_en = ~RAM_en;
      tick();
      chk("rst_nwe", 32'(RAM_nWE), 32'h1);
      chk("rst_vdata", 32'(vDATABUS), 32'h00);
      chk("rst_cpudi", 32'(CPU_DI), 32'h00);
      chk("rst_valid", 32'(VID_VALID), 32'h0);
    end
    RAM_en = 1'b0;
    nRESET = 1'b1;
    tick();

    poke(8'h03, 8'hA5);
    FRAMESTORE_ADR = 14'h0600; ROW_ADDRESS = 5'd3;
    start_vid();
    chk("lin_adr", 32'(RAM_ADR), 32'h3003);
    pulse(1'b0);
    chk("lin_data", 32'(vDATABUS), 32'hA5);
    chk("lin_valid", 32'(VID_VALID), 32'h1);
    tick();
    chk("valid_one_cycle", 32'(VID_VALID), 32'h0);

    FRAMESTORE_ADR = 14'h1000; ROW_ADDRESS = 5'd0; SCREEN_SIZE = 2'b00;
    start_vid();
    chk("wrap_ss0", 32'(RAM_ADR), 32'h3000);
    SCREEN_SIZE = 2'b11;
    start_vid();
    chk("wrap_ss3", 32'(RAM_ADR), 32'h6000);

    FRAMESTORE_ADR = 14'h2005;
    for (int r = 0; r < 32; r += 13) begin
      ROW_ADDRESS = 5'(r);
      start_vid();
      chk("ttx_adr", 32'(RAM_ADR), 32'h7C05);
    end

    CPU_REQ = 1'b1; CPU_RnW = 1'b0; CPU_ADR = 15'h1234; CPU_DO = 8'h5A;
    pulse(1'b1);
    chk("wr_nwe", 32'(RAM_nWE), 32'h0);
    chk("wr_adr", 32'(RAM_ADR), 32'h1234);
    chk("wr_do", 32'(RAM_DO), 32'h5A);
    CPU_DO = 8'hFF; CPU_ADR = 15'h0000; CPU_RnW = 1'b1;
    tick(); tick();
    chk("wr_do_held", 32'(RAM_DO), 32'h5A);
    chk("wr_adr_held", 32'(RAM_ADR), 32'h1234);
    chk("wr_nwe_held", 32'(RAM_nWE), 32'h0);
    CPU_REQ = 1'b0;
    pulse(1'b0);
    chk("wr_end_nwe", 32'(RAM_nWE), 32'h1);

    poke(8'h00, 8'h3C);
    CPU_REQ = 1'b1; CPU_RnW = 1'b1; CPU_ADR = 15'h0100;
    pulse(1'b1);
    CPU_RnW = 1'b0; CPU_ADR = 15'h0222; CPU_DO = 8'h77;
    pulse(1'b1);
    chk("rd_cpudi", 32'(CPU_DI), 32'h3C);
    chk("b2b_wr_nwe", 32'(RAM_nWE), 32'h0);
    nRESET = 1'b0;
    tick();
    chk("rst_mid_wr", 32'(RAM_nWE), 32'h1);
    nRESET = 1'b1;
    CPU_REQ = 1'b0;
    tick();

    repeat (4000) begin
      nRESET = ($urandom_range(0, 499) != 0);
      RAM_en = ($urandom_range(0, 2) == 0);
      PROC_en = RAM_en ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      FRAMESTORE_ADR = 14'($urandom);
      ROW_ADDRESS = 5'($urandom);
      SCREEN_SIZE = 2'($urandom);
      CPU_REQ = ($urandom_range(0, 3) != 0);
      CPU_RnW = 1'($urandom);
      CPU_ADR = 15'($urandom);
      CPU_DO = 8'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
